// File: rtl/avalon_mm_ram_agent_pkg.sv
// avalon_mm_ram_agent_pkg: shared types for the Avalon-MM RAM agent and its byte-lane RAM
// Contents: avalon_response_t (Avalon response encoding), byte_enable_t (4 lane write enables)
package avalon_mm_ram_agent_pkg;
  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    RESERVED    = 2'b01,
    SLAVEERROR  = 2'b10,
    DECODEERROR = 2'b11
  } avalon_response_t;
  typedef bit [3:0] byte_enable_t;
endpackage

// File: rtl/avalon_mm_ram_agent_ram.sv
// byte_enable_ram: WORDS x 32-bit array, synchronous per-lane write, asynchronous read
// Ports: clk; we_i lane write enables; addr_i word index shared by write and read; wdata_i; rdata_o
module byte_enable_ram
  import avalon_mm_ram_agent_pkg::*;
#(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  byte_enable_t             we_i,
  input  logic [$clog2(WORDS)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] mem_q [WORDS];
  always_ff @(posedge clk)
    for (int n = 0; n < 4; n++)
      if (we_i[n]) mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/avalon_mm_ram_agent.sv
// avalon_mm_ram_agent: Avalon-MM responder around a byte-lane RAM with wait states and a fixed-latency read pipeline
// Ports: clk, rst (sync, active-high); address/read/write/byteenable/host_to_agent from the host;
//        waitrequest stall; agent_to_host + readdatavalid read response;
//        response [1:0] exists only when AVALON_RAM_RESPONSE_EN is defined (error-checked accesses).
module avalon_mm_ram_agent
  import avalon_mm_ram_agent_pkg::*;
#(
  parameter int WORDS        = 1024,
  parameter int WAIT_STATES  = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] host_to_agent,
  output logic [31:0] agent_to_host,
  output logic        waitrequest,
  output logic        readdatavalid
`ifdef AVALON_RAM_RESPONSE_EN
  ,
  output logic [1:0]  response
`endif
);
  localparam int AW = $clog2(WORDS);
  logic cmd, acc, rd_acc, wr_acc;
  logic [3:0] wait_q, wait_d;
  logic [31:0] ram_rdata, rd_word;
  byte_enable_t we;
  logic [READ_LATENCY-1:0] v_q;
  logic [31:0] d_q [READ_LATENCY];
`ifdef AVALON_RAM_RESPONSE_EN
  logic err;
  logic [READ_LATENCY-1:0] e_q;
  logic wr_err_q;
  assign err = (|address[1:0]) || (|address[31:AW+2]);
`else
  localparam logic err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{address[31:AW+2], address[1:0]};
`endif
  assign cmd = read || write;
  assign waitrequest = rst || (cmd && wait_q != 4'(WAIT_STATES));
  assign acc = cmd && !waitrequest;
  // a read colliding with a write gets no read response; the write still happens
  assign rd_acc = acc && read && !write;
  assign wr_acc = acc && write;
  assign wait_d = acc ? 4'd0 : cmd ? wait_q + 4'd1 : wait_q;
  assign we = (wr_acc && !err) ? byte_enable_t'(byteenable) : '0;
  assign rd_word = err ? '0 : ram_rdata;
  byte_enable_ram #(.WORDS(WORDS)) u_ram (
    .clk(clk),
    .we_i(we),
    .addr_i(address[AW+1:2]),
    .wdata_i(host_to_agent),
    .rdata_o(ram_rdata)
  );
  // data stages only load behind a valid stage so the output holds its last response
  always_ff @(posedge clk)
    if (rst) begin
      wait_q <= '0;
      v_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d_q[i] <= '0;
    end else begin
      wait_q <= wait_d;
      v_q[0] <= rd_acc;
      if (rd_acc) d_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  assign agent_to_host = d_q[READ_LATENCY-1];
  assign readdatavalid = v_q[READ_LATENCY-1];
`ifdef AVALON_RAM_RESPONSE_EN
  always_ff @(posedge clk)
    if (rst) begin
      e_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      e_q[0] <= err;
      for (int i = 1; i < READ_LATENCY; i++) e_q[i] <= e_q[i-1];
      if (wr_acc) wr_err_q <= err || read;
    end
  assign response = readdatavalid ? (e_q[READ_LATENCY-1] ? SLAVEERROR : OKAY)
                                  : (wr_err_q ? SLAVEERROR : OKAY);
`endif
  assert property (@(posedge clk) disable iff (rst) !(acc && read && write))
    else $error("avalon_mm_ram_agent: read and write accepted together");
endmodule
